// File: rtl/pu_pio_master_pkg.sv
// ---------------------------------------------------------------------------
// pu_pio_master_pkg
// Shared definitions for the PU PIO register-bus initiator:
//   - default data/address width of the PIO bus
//   - default timeout counter width and timeout value
//   - state encoding of the initiator FSM
// ---------------------------------------------------------------------------
`ifndef PIO_RANGE
`define PIO_RANGE pu_pio_master_pkg::PIO_NBITS-1:0
`endif

package pu_pio_master_pkg;

    localparam int PIO_NBITS    = 32;
    localparam int TO_NBITS_DEF = 12;
    localparam int TIMEOUT_DEF  = 4095;

    typedef enum logic [1:0] {
        PIOM_IDLE  = 2'd0,
        PIOM_ISSUE = 2'd1,
        PIOM_WAIT  = 2'd2,
        PIOM_RESP  = 2'd3
    } piom_state_e;

endpackage

// File: rtl/pu_pio_master_if.sv
// ---------------------------------------------------------------------------
// pu_pio_master_if
// Bundles the host request/response handshake and the PIO bus between the
// host bridge, the initiator and the PU PIO decoder.
//   master : initiator side (pu_pio_master)
//   slave  : host + responder side (bridge / decoder / testbench)
// ---------------------------------------------------------------------------
interface pu_pio_master_if #(
    parameter int PIO_NBITS = pu_pio_master_pkg::PIO_NBITS
);
    // host request
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_wr;
    logic [PIO_NBITS-1:0] req_addr;
    logic [PIO_NBITS-1:0] req_wdata;
    // host response
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [PIO_NBITS-1:0] rsp_rdata;
    logic                 rsp_err;
    // PIO bus towards the responder
    logic                 reg_bs;
    logic                 reg_rd;
    logic                 reg_wr;
    logic [PIO_NBITS-1:0] reg_addr;
    logic [PIO_NBITS-1:0] reg_din;
    logic                 pio_ack;
    logic                 pio_rvalid;
    logic [PIO_NBITS-1:0] pio_rdata;

    modport master (
        input  req_valid, req_wr, req_addr, req_wdata, rsp_ready,
               pio_ack, pio_rvalid, pio_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               reg_bs, reg_rd, reg_wr, reg_addr, reg_din
    );

    modport slave (
        output req_valid, req_wr, req_addr, req_wdata, rsp_ready,
               pio_ack, pio_rvalid, pio_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               reg_bs, reg_rd, reg_wr, reg_addr, reg_din
    );
endinterface

// File: rtl/pu_pio_timeout.sv
// ---------------------------------------------------------------------------
// pu_pio_timeout
// Clearable, enabled up-counter with a terminal-count flag.
//   clk, rst_n : clock, async active-low reset
//   clr_i      : synchronous clear to 0 (wins over en_i)
//   en_i       : count up by one
//   tc_o       : count has reached TIMEOUT-1
// The owner stops enabling the counter once tc_o is seen, so it never wraps.
// ---------------------------------------------------------------------------
module pu_pio_timeout #(
    parameter int TO_NBITS = pu_pio_master_pkg::TO_NBITS_DEF,
    parameter int TIMEOUT  = pu_pio_master_pkg::TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);
    logic [TO_NBITS-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i)
            count_d = '0;
        else if (en_i)
            count_d = count_q + TO_NBITS'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign tc_o = (count_q == TO_NBITS'(TIMEOUT - 1));

endmodule

// File: rtl/pu_pio_master.sv
// ---------------------------------------------------------------------------
// pu_pio_master
// Initiator end of the PU PIO register bus. Accepts one host request at a
// time, issues a one-cycle reg_rd/reg_wr strobe with reg_bs held for the
// whole transaction, waits for a rising edge of pio_ack (or a timeout) and
// returns a single response.
//   clk, rst_n : clock, async active-low reset
//   bus        : pu_pio_master_if.master (host handshake + PIO bus)
// All outputs are registered except req_ready (decoded from state).
// ---------------------------------------------------------------------------
module pu_pio_master #(
    parameter int PIO_NBITS = pu_pio_master_pkg::PIO_NBITS,
    parameter int TO_NBITS  = pu_pio_master_pkg::TO_NBITS_DEF,
    parameter int TIMEOUT   = pu_pio_master_pkg::TIMEOUT_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    pu_pio_master_if.master bus
);
    import pu_pio_master_pkg::*;

    piom_state_e          state_q, state_d;
    logic                 ack_q;
    logic                 ack_edge;
    logic                 wr_q, wr_d;
    logic                 reg_bs_q, reg_bs_d;
    logic                 reg_rd_q, reg_rd_d;
    logic                 reg_wr_q, reg_wr_d;
    logic [PIO_NBITS-1:0] reg_addr_q, reg_addr_d;
    logic [PIO_NBITS-1:0] reg_din_q, reg_din_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [PIO_NBITS-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                 rsp_err_q, rsp_err_d;
    logic                 to_clr, to_en, to_tc;

    // Only a rising ack completes a transaction, so a level left high by the
    // previous transaction cannot complete the next one.
    assign ack_edge = bus.pio_ack & ~ack_q;

    pu_pio_timeout #(
        .TO_NBITS (TO_NBITS),
        .TIMEOUT  (TIMEOUT)
    ) u_timeout (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (to_clr),
        .en_i  (to_en),
        .tc_o  (to_tc)
    );

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= PIOM_IDLE;
            ack_q       <= 1'b0;
            wr_q        <= 1'b0;
            reg_bs_q    <= 1'b0;
            reg_rd_q    <= 1'b0;
            reg_wr_q    <= 1'b0;
            reg_addr_q  <= '0;
            reg_din_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ack_q       <= bus.pio_ack;
            wr_q        <= wr_d;
            reg_bs_q    <= reg_bs_d;
            reg_rd_q    <= reg_rd_d;
            reg_wr_q    <= reg_wr_d;
            reg_addr_q  <= reg_addr_d;
            reg_din_q   <= reg_din_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            PIOM_IDLE:  if (bus.req_valid) state_d = PIOM_ISSUE;
            PIOM_ISSUE: state_d = PIOM_WAIT;
            PIOM_WAIT:  if (ack_edge || to_tc) state_d = PIOM_RESP;
            PIOM_RESP:  if (bus.rsp_ready) state_d = PIOM_IDLE;
            default:    state_d = PIOM_IDLE;
        endcase
    end

    // Output / datapath next values.
    // NOTE: every signal gets a default first so no path through the case
    // leaves it unassigned and infers a latch.
    always_comb begin
        wr_d        = wr_q;
        reg_bs_d    = reg_bs_q;
        reg_rd_d    = 1'b0;
        reg_wr_d    = 1'b0;
        reg_addr_d  = reg_addr_q;
        reg_din_d   = reg_din_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        to_clr      = 1'b0;
        to_en       = 1'b0;
        case (state_q)
            PIOM_IDLE: begin
                if (bus.req_valid) begin
                    wr_d       = bus.req_wr;
                    reg_addr_d = bus.req_addr;
                    reg_din_d  = bus.req_wr ? bus.req_wdata : '0;
                    reg_bs_d   = 1'b1;
                    reg_rd_d   = ~bus.req_wr;
                    reg_wr_d   = bus.req_wr;
                end
            end
            PIOM_ISSUE: to_clr = 1'b1;
            PIOM_WAIT: begin
                // An ack in the terminal-count cycle still wins over timeout.
                if (ack_edge) begin
                    rsp_err_d   = ~wr_q & ~bus.pio_rvalid;
                    rsp_rdata_d = (~wr_q & bus.pio_rvalid) ? bus.pio_rdata : '0;
                    reg_bs_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                end else if (to_tc) begin
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                    reg_bs_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                end else begin
                    to_en = 1'b1;
                end
            end
            PIOM_RESP: if (bus.rsp_ready) rsp_valid_d = 1'b0;
            default: ;
        endcase
    end

    assign bus.req_ready = (state_q == PIOM_IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.reg_bs    = reg_bs_q;
    assign bus.reg_rd    = reg_rd_q;
    assign bus.reg_wr    = reg_wr_q;
    assign bus.reg_addr  = reg_addr_q;
    assign bus.reg_din   = reg_din_q;

endmodule

// File: tb/tb_pu_pio_master.sv
// ---------------------------------------------------------------------------
// tb_pu_pio_master
// Self-checking bench for pu_pio_master (TIMEOUT=16). Each transaction is
// described by an ack waveform indexed by cycle (cycle 0 = accept cycle,
// cycle 1 = strobe cycle). The expected response cycle and fields come from
// scanning that waveform for the first rising ack inside the wait window.
// ---------------------------------------------------------------------------
module tb_pu_pio_master;

    localparam int NB  = 32;
    localparam int TON = 12;
    localparam int TO  = 16;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    pu_pio_master_if #(.PIO_NBITS(NB)) bus ();

    pu_pio_master #(
        .PIO_NBITS (NB),
        .TO_NBITS  (TON),
        .TIMEOUT   (TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic pat_at(input logic [63:0] pat, input int c);
        return pat[(c > 63) ? 63 : c];
    endfunction

    // One complete transaction with the responder following `pat`, the host
    // holding rsp_ready low for `bp` cycles after rsp_valid appears.
    task automatic do_txn(input string name, input logic wr,
                          input logic [NB-1:0] addr, input logic [NB-1:0] wdata,
                          input logic rvalid, input logic [NB-1:0] rdata,
                          input logic [63:0] pat, input int bp);
        int             exp_cyc;
        logic           acked;
        logic           exp_err;
        logic [NB-1:0]  exp_rdata;
        logic [NB-1:0]  exp_din;
        int             cyc;
        int             strobes;
        logic           stable;
        logic           got;
        logic           hold_ok;

        // reference model
        exp_cyc = TO + 2;
        acked   = 1'b0;
        for (int c = 2; c <= TO + 1; c++) begin
            if (pat_at(pat, c) && !pat_at(pat, c - 1)) begin
                exp_cyc = c + 1;
                acked   = 1'b1;
                break;
            end
        end
        exp_err   = acked ? (!wr && !rvalid) : 1'b1;
        exp_rdata = (acked && !wr && rvalid) ? rdata : '0;
        exp_din   = wr ? wdata : '0;

        checks++;
        if (bus.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s/ready_idle: req_ready=%b expected 1", name, bus.req_ready);
        end

        // cycle 0: present request
        bus.req_valid  = 1'b1;
        bus.req_wr     = wr;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.pio_rvalid = rvalid;
        bus.pio_rdata  = rdata;
        bus.pio_ack    = pat_at(pat, 0);
        tick();
        bus.req_valid  = 1'b0;
        bus.req_addr   = $urandom;
        bus.req_wdata  = $urandom;
        cyc = 1;

        checks++;
        if (bus.reg_bs !== 1'b1 || bus.reg_rd !== !wr || bus.reg_wr !== wr ||
            bus.reg_addr !== addr || bus.reg_din !== exp_din || bus.req_ready !== 1'b0) begin
            failures++;
            $display("FAIL %s/issue: bs=%b rd=%b wr=%b addr=%h din=%h rdy=%b expected bs=1 rd=%b wr=%b addr=%h din=%h rdy=0",
                     name, bus.reg_bs, bus.reg_rd, bus.reg_wr, bus.reg_addr, bus.reg_din,
                     bus.req_ready, !wr, wr, addr, exp_din);
        end

        strobes = 0;
        stable  = 1'b1;
        got     = 1'b0;
        while (!got && cyc < 100) begin
            if (bus.reg_rd || bus.reg_wr) strobes++;
            if (bus.rsp_valid) begin
                got = 1'b1;
            end else begin
                if (bus.reg_bs !== 1'b1 || bus.reg_addr !== addr ||
                    bus.reg_din !== exp_din || bus.req_ready !== 1'b0)
                    stable = 1'b0;
                bus.pio_ack = pat_at(pat, cyc);
                tick();
                cyc++;
            end
        end

        checks++;
        if (!got) begin
            failures++;
            $display("FAIL %s/rsp_timeout: no rsp_valid within %0d cycles", name, cyc);
            return;
        end

        checks++;
        if (strobes !== 1 || stable !== 1'b1) begin
            failures++;
            $display("FAIL %s/bus_hold: strobe_cycles=%0d bus_stable=%b expected 1 and 1",
                     name, strobes, stable);
        end

        checks++;
        if (cyc !== exp_cyc) begin
            failures++;
            $display("FAIL %s/latency: rsp_valid at cycle %0d expected %0d", name, cyc, exp_cyc);
        end

        checks++;
        if (bus.rsp_err !== exp_err || bus.rsp_rdata !== exp_rdata || bus.reg_bs !== 1'b0) begin
            failures++;
            $display("FAIL %s/rsp: err=%b rdata=%h bs=%b expected err=%b rdata=%h bs=0",
                     name, bus.rsp_err, bus.rsp_rdata, bus.reg_bs, exp_err, exp_rdata);
        end

        hold_ok = 1'b1;
        for (int i = 0; i < bp; i++) begin
            tick();
            if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== exp_err ||
                bus.rsp_rdata !== exp_rdata || bus.req_ready !== 1'b0)
                hold_ok = 1'b0;
        end
        if (bp > 0) begin
            checks++;
            if (hold_ok !== 1'b1) begin
                failures++;
                $display("FAIL %s/backpressure: response not held stable over %0d cycles", name, bp);
            end
        end

        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s/handshake: rsp_valid=%b req_ready=%b expected 0 and 1",
                     name, bus.rsp_valid, bus.req_ready);
        end
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_wr     = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.rsp_ready  = 1'b0;
        bus.pio_ack    = 1'b0;
        bus.pio_rvalid = 1'b0;
        bus.pio_rdata  = '0;
        repeat (3) tick();
        checks++;
        if (bus.reg_bs !== 1'b0 || bus.reg_rd !== 1'b0 || bus.reg_wr !== 1'b0 ||
            bus.reg_addr !== '0 || bus.reg_din !== '0 || bus.rsp_valid !== 1'b0 ||
            bus.rsp_rdata !== '0 || bus.rsp_err !== 1'b0 || bus.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset/outputs: bs=%b rd=%b wr=%b addr=%h din=%h rv=%b rdata=%h err=%b rdy=%b expected all 0 and rdy=1",
                     bus.reg_bs, bus.reg_rd, bus.reg_wr, bus.reg_addr, bus.reg_din,
                     bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.req_ready);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_write();
        do_txn("write", 1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 1'b1, 32'hCAFE_F00D,
               64'd1 << 6, 0);
    endtask

    task automatic test_read();
        do_txn("read", 1'b0, 32'h0000_2008, 32'hFFFF_FFFF, 1'b1, 32'h1234_5678,
               64'd1 << 3, 0);
    endtask

    task automatic test_unmapped();
        // minimum latency: ack in cycle 2, response in cycle 3
        do_txn("unmapped", 1'b0, 32'h0000_FFFC, 32'h0, 1'b0, 32'h5A5A_A5A5,
               64'd1 << 2, 0);
    endtask

    task automatic test_timeout();
        do_txn("timeout_wr", 1'b1, 32'h0000_0040, 32'h0BAD_0001, 1'b1, 32'h1, 64'd0, 0);
        do_txn("timeout_rd", 1'b0, 32'h0000_0044, 32'h0, 1'b1, 32'h7777_0000, 64'd0, 0);
        do_txn("after_timeout", 1'b0, 32'h0000_0048, 32'h0, 1'b1, 32'h0A0B_0C0D,
               64'd1 << 4, 0);
    endtask

    task automatic test_stale_ack();
        logic [63:0] p;
        p = {64{1'b1}} << 3;
        do_txn("stale_first", 1'b0, 32'h100, 32'h0, 1'b1, 32'h1111_2222, p, 0);
        p = ~(64'h7 << 5);
        do_txn("stale_refire", 1'b0, 32'h104, 32'h0, 1'b1, 32'h3333_4444, p, 0);
        p = {64{1'b1}};
        do_txn("stale_never", 1'b1, 32'h108, 32'h5555_6666, 1'b1, 32'h0, p, 0);
        do_txn("stale_cleared", 1'b1, 32'h10C, 32'h7777_8888, 1'b1, 32'h0, 64'd1 << 4, 0);
    endtask

    task automatic test_ack_at_tc();
        do_txn("ack_at_tc", 1'b0, 32'h200, 32'h0, 1'b1, 32'h9876_5432,
               64'd1 << (TO + 1), 0);
        do_txn("ack_after_tc", 1'b0, 32'h204, 32'h0, 1'b1, 32'h9876_5433,
               64'd1 << (TO + 2), 0);
    endtask

    task automatic test_backpressure();
        do_txn("backpressure", 1'b0, 32'h300, 32'h0, 1'b1, 32'hFEED_FACE, 64'd1 << 5, 10);
    endtask

    task automatic test_reset_mid();
        logic seen;
        bus.req_valid = 1'b1;
        bus.req_wr    = 1'b1;
        bus.req_addr  = 32'h400;
        bus.req_wdata = 32'hABCD_EF01;
        bus.pio_ack   = 1'b0;
        tick();
        bus.req_valid = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.reg_bs !== 1'b0 || bus.reg_rd !== 1'b0 || bus.reg_wr !== 1'b0 ||
            bus.reg_addr !== '0 || bus.reg_din !== '0 || bus.rsp_valid !== 1'b0 ||
            bus.rsp_rdata !== '0 || bus.rsp_err !== 1'b0 || bus.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid/outputs: bs=%b addr=%h din=%h rv=%b err=%b rdy=%b expected 0,0,0,0,0,1",
                     bus.reg_bs, bus.reg_addr, bus.reg_din, bus.rsp_valid, bus.rsp_err,
                     bus.req_ready);
        end
        tick();
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (TO + 4) begin
            tick();
            if (bus.rsp_valid !== 1'b0 || bus.reg_bs !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid/no_rsp: activity seen after reset, expected none");
        end
        do_txn("after_reset", 1'b0, 32'h404, 32'h0, 1'b1, 32'h2468_ACE0, 64'd1 << 2, 0);
    endtask

    task automatic test_random();
        logic [63:0] p;
        int          pos;
        for (int n = 0; n < 40; n++) begin
            pos = $urandom_range(0, TO + 6);
            p   = (pos <= TO + 4) ? (64'd1 << pos) : 64'd0;
            do_txn("random", 1'($urandom_range(0, 1)), $urandom, $urandom,
                   1'($urandom_range(0, 1)), $urandom, p, $urandom_range(0, 3));
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_write();
        test_read();
        test_unmapped();
        test_timeout();
        test_stale_ack();
        test_ack_at_tc();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
